// File: rtl/z_core_inst_encoder.sv
// z_core_inst_encoder: packs decoded RV32I fields back into 32-bit instruction
// words, tags each legal word with a sequential instruction-memory address and
// queues {inst, addr} in a small output FIFO.
//
// Optional feature: define Z_CORE_ENC_IMM_CHECK_EN to reject immediates that do
// not fit their format. Without it, out-of-range immediate bits are truncated.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_valid / in_ready    field bundle handshake (in_ready = FIFO not full)
//   op, rd, rs1, rs2       opcode and register indices
//   funct3, funct7, imm    function fields, sign-extended 32-bit immediate
//   addr_clr               reload address counter with BASE_ADDR
//   out_valid / out_ready  FIFO head handshake
//   out_inst, out_addr     head word and its address (0 when empty)
//   err, err_count         sticky error flag, saturating reject counter
module z_core_inst_encoder #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  input  logic        addr_clr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_addr,
  output logic        err,
  output logic [7:0]  err_count
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [2:0] {FmtR, FmtI, FmtS, FmtB, FmtU, FmtJ, FmtBad} fmt_e;

  fmt_e        fmt;
  logic [31:0] enc;
  logic        imm_ok;
  logic        legal;

  // Format selection and packing.
  always_comb begin
    fmt = FmtBad;
    unique case (op)
      7'b0110011:                                      fmt = FmtR;
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: fmt = FmtI;
      7'b0100011:                                      fmt = FmtS;
      7'b1100011:                                      fmt = FmtB;
      7'b0110111, 7'b0010111:                          fmt = FmtU;
      7'b1101111:                                      fmt = FmtJ;
      default:                                         fmt = FmtBad;
    endcase

    enc = '0;
    unique case (fmt)
      FmtR: enc = {funct7, rs2, rs1, funct3, rd, op};
      FmtI: enc = {imm[11:0], rs1, funct3, rd, op};
      FmtS: enc = {imm[11:5], rs2, rs1, funct3, imm[4:0], op};
      FmtB: enc = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op};
      FmtU: enc = {imm[31:12], rd, op};
      FmtJ: enc = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
      default: enc = '0;
    endcase
  end

`ifdef Z_CORE_ENC_IMM_CHECK_EN
  // Upper bits must replicate the format's sign bit; B/J offsets must be even.
  always_comb begin
    imm_ok = 1'b1;
    unique case (fmt)
      FmtI, FmtS: imm_ok = (imm[31:11] == {21{imm[11]}});
      FmtB:       imm_ok = (imm[31:12] == {20{imm[12]}}) && !imm[0];
      FmtJ:       imm_ok = (imm[31:20] == {12{imm[20]}}) && !imm[0];
      FmtU:       imm_ok = (imm[11:0] == 12'h000);
      default:    imm_ok = 1'b1;
    endcase
  end
`else
  assign imm_ok = 1'b1;
`endif

  assign legal = (fmt != FmtBad) && imm_ok;

  // FIFO state: pointers carry one extra wrap bit to tell full from empty.
  logic [PtrW:0]  wr_ptr_q, rd_ptr_q;
  logic [31:0]    mem_inst_q [FIFO_DEPTH];
  logic [31:0]    mem_addr_q [FIFO_DEPTH];
  logic [31:0]    addr_q;
  logic           err_q;
  logic [7:0]     err_count_q;
  logic           empty, full, accept, push, pop;
  logic [PtrW-1:0] wr_idx, rd_idx;

  assign wr_idx = wr_ptr_q[PtrW-1:0];
  assign rd_idx = rd_ptr_q[PtrW-1:0];
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) && (wr_idx == rd_idx);

  // Gating with rst suppresses any handshake in a reset cycle.
  assign in_ready  = !rst && !full;
  assign out_valid = !rst && !empty;
  assign out_inst  = out_valid ? mem_inst_q[rd_idx] : '0;
  assign out_addr  = out_valid ? mem_addr_q[rd_idx] : '0;
  assign err       = err_q;
  assign err_count = err_count_q;

  assign accept = in_valid && in_ready;
  assign push   = accept && legal;
  assign pop    = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      addr_q      <= BASE_ADDR;
      err_q       <= 1'b0;
      err_count_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      // addr_clr wins over the increment; the accepted word keeps the old address.
      if (addr_clr)  addr_q <= BASE_ADDR;
      else if (push) addr_q <= addr_q + 32'd4;
      if (accept && !legal) begin
        err_q <= 1'b1;
        if (err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
      end
    end
  end

  // Storage needs no reset: outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_inst_q[wr_idx] <= enc;
      mem_addr_q[wr_idx] <= addr_q;
    end
  end

endmodule

// File: tb/tb_z_core_inst_encoder.sv
module tb_z_core_inst_encoder;

  localparam int unsigned DEPTH = 4;
  localparam bit [31:0]   BASE  = 32'h0000_0000;

  logic        clk = 0;
  logic        rst = 1;
  logic        in_valid = 0;
  logic        in_ready;
  logic [6:0]  op = 0;
  logic [4:0]  rd = 0, rs1 = 0, rs2 = 0;
  logic [2:0]  funct3 = 0;
  logic [6:0]  funct7 = 0;
  logic [31:0] imm = 0;
  logic        addr_clr = 0;
  logic        out_valid;
  logic        out_ready = 0;
  logic [31:0] out_inst, out_addr;
  logic        err;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;

  z_core_inst_encoder #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .rd(rd),
    .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7), .imm(imm),
    .addr_clr(addr_clr), .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_addr(out_addr), .err(err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoder built from shifts and masks of the field values.
  function automatic bit [32:0] model_enc(input int unsigned o, input int unsigned d,
                                          input int unsigned s1, input int unsigned s2,
                                          input int unsigned f3, input int unsigned f7,
                                          input int unsigned im);
    bit [31:0] w;
    bit ok;
    int signed si;
    si = im;
    ok = 1;
    w  = 0;
    case (o)
      'h33: w = (f7 << 25) | (s2 << 20) | (s1 << 15) | (f3 << 12) | (d << 7) | o;
      'h13, 'h03, 'h67, 'h73: begin
        w = ((im & 'hfff) << 20) | (s1 << 15) | (f3 << 12) | (d << 7) | o;
        ok = (si >= -2048) && (si <= 2047);
      end
      'h23: begin
        w = (((im >> 5) & 'h7f) << 25) | (s2 << 20) | (s1 << 15) | (f3 << 12)
            | ((im & 'h1f) << 7) | o;
        ok = (si >= -2048) && (si <= 2047);
      end
      'h63: begin
        w = (((im >> 12) & 1) << 31) | (((im >> 5) & 'h3f) << 25) | (s2 << 20) | (s1 << 15)
            | (f3 << 12) | (((im >> 1) & 'hf) << 8) | (((im >> 11) & 1) << 7) | o;
        ok = (si >= -4096) && (si <= 4095) && (im % 2 == 0);
      end
      'h37, 'h17: begin
        w = (im & 'hfffff000) | (d << 7) | o;
        ok = (im & 'hfff) == 0;
      end
      'h6f: begin
        w = (((im >> 20) & 1) << 31) | (((im >> 1) & 'h3ff) << 21) | (((im >> 11) & 1) << 20)
            | (((im >> 12) & 'hff) << 12) | (d << 7) | o;
        ok = (si >= -(1 << 20)) && (si < (1 << 20)) && (im % 2 == 0);
      end
      default: return {1'b0, 32'h0};
    endcase
`ifndef Z_CORE_ENC_IMM_CHECK_EN
    ok = 1;
`endif
    return {ok, w};
  endfunction

  // Scoreboard model: queue of {inst, addr}, address counter, error state.
  bit [63:0] q[$];
  bit [31:0] m_addr = BASE;
  bit        m_err = 0;
  int        m_cnt = 0;

  always @(posedge clk) begin
    bit acc, popv;
    bit [32:0] r;
    if (rst) begin
      q.delete();
      m_addr = BASE;
      m_err  = 0;
      m_cnt  = 0;
    end else begin
      acc  = in_valid && (q.size() < DEPTH);
      popv = out_ready && (q.size() != 0);
      r = model_enc(op, rd, rs1, rs2, funct3, funct7, imm);
      if (popv) void'(q.pop_front());
      if (acc && r[32]) begin
        q.push_back({r[31:0], m_addr});
        m_addr = m_addr + 4;
      end
      if (acc && !r[32]) begin
        m_err = 1;
        if (m_cnt < 255) m_cnt++;
      end
      if (addr_clr) m_addr = BASE;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready", {31'b0, in_ready}, {31'b0, q.size() < DEPTH});
      chk("out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
      chk("out_inst", out_inst, q.size() != 0 ? q[0][63:32] : 32'h0);
      chk("out_addr", out_addr, q.size() != 0 ? q[0][31:0] : 32'h0);
      chk("err", {31'b0, err}, {31'b0, m_err});
      chk("err_count", {24'b0, err_count}, m_cnt);
    end
  end

  task automatic set_f(input logic [6:0] o, input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] im);
    in_valid = 1; op = o; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
  endtask

  task automatic idle();
    in_valid = 0; addr_clr = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    idle(); rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  initial begin
    do_reset();
    @(negedge clk);
    chk("rst_in_ready", {31'b0, in_ready}, 32'h1);
    chk("rst_out_inst", out_inst, 32'h0);
    chk("rst_err_count", {24'b0, err_count}, 32'h0);

    // addi x2, x0, 3
    out_ready = 1;
    @(posedge clk); #1 set_f(7'h13, 2, 0, 0, 0, 0, 3);
    @(posedge clk); #1 idle();
    @(negedge clk);
    chk("addi_inst", out_inst, 32'h00300113);
    chk("addi_addr", out_addr, 32'h0);

    // sw then add back to back
    do_reset();
    set_f(7'h23, 0, 1, 2, 0, 0, 16);
    @(posedge clk); #1 set_f(7'h33, 3, 1, 2, 0, 0, 0);
    @(negedge clk);
    chk("sw_inst", out_inst, 32'h00208823);
    chk("sw_addr", out_addr, 32'h0);
    @(posedge clk); #1 idle();
    @(negedge clk);
    chk("add_inst", out_inst, 32'h002081B3);
    chk("add_addr", out_addr, 32'h4);

    // jal then lui
    do_reset();
    set_f(7'h6f, 1, 0, 0, 0, 0, 2048);
    @(posedge clk); #1 set_f(7'h37, 5, 0, 0, 0, 0, 32'h12345000);
    @(negedge clk);
    chk("jal_inst", out_inst, 32'h001000EF);
    @(posedge clk); #1 idle();
    @(negedge clk);
    chk("lui_inst", out_inst, 32'h123452B7);

    // branch with negative offset, exercised via the model only
    @(posedge clk); #1 set_f(7'h63, 0, 3, 4, 1, 0, 32'hFFFFFFF8);
    @(posedge clk); #1 idle();

    // illegal opcode between two legal bundles
    do_reset();
    set_f(7'h13, 2, 0, 0, 0, 0, 3);
    @(posedge clk); #1 set_f(7'h7f, 1, 1, 1, 0, 0, 0);
    @(posedge clk); #1 set_f(7'h33, 3, 1, 2, 0, 0, 0);
    @(negedge clk);
    chk("ill_err", {31'b0, err}, 32'h1);
    chk("ill_err_count", {24'b0, err_count}, 32'h1);
    @(posedge clk); #1 idle();
    @(negedge clk);
    chk("ill_next_addr", out_addr, 32'h4);

    // fill with out_ready low, then drain
    do_reset();
    out_ready = 0;
    for (int i = 1; i <= 6; i++) begin
      set_f(7'h13, 5'(i), 0, 0, 0, 0, 3);
      @(posedge clk); #1;
    end
    idle();
    @(negedge clk);
    chk("full_in_ready", {31'b0, in_ready}, 32'h0);
    @(posedge clk); #1 out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("drain_inst", out_inst, 32'h00300013 | ((i + 1) << 7));
      chk("drain_addr", out_addr, 4 * i);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("drain_empty", {31'b0, out_valid}, 32'h0);

    // addr_clr together with an accept
    do_reset();
    set_f(7'h13, 1, 0, 0, 0, 0, 1);
    @(posedge clk); #1 set_f(7'h13, 2, 0, 0, 0, 0, 2); addr_clr = 1;
    @(negedge clk);
    @(posedge clk); #1 addr_clr = 0; set_f(7'h13, 3, 0, 0, 0, 0, 3);
    @(negedge clk);
    chk("clr_old_addr", out_addr, 32'h4);
    @(posedge clk); #1 idle();
    @(negedge clk);
    chk("clr_new_addr", out_addr, BASE);

    // reset mid-stream discards contents
    out_ready = 0;
    set_f(7'h13, 4, 0, 0, 0, 0, 4);
    repeat (2) @(posedge clk);
    #1 idle(); rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("midrst_valid", {31'b0, out_valid}, 32'h0);
    chk("midrst_err", {31'b0, err}, 32'h0);

    // out-of-range I immediate
    out_ready = 1;
    set_f(7'h13, 2, 0, 0, 0, 0, 32'h800);
    @(posedge clk); #1 idle();
    @(negedge clk);
`ifdef Z_CORE_ENC_IMM_CHECK_EN
    chk("immchk_err", {31'b0, err}, 32'h1);
    chk("immchk_valid", {31'b0, out_valid}, 32'h0);
`else
    chk("trunc_inst", out_inst, 32'h80000113);
    chk("trunc_err", {31'b0, err}, 32'h0);
`endif
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/z_core_inst_encoder.md
# z_core_inst_encoder

Sequential RISC-V RV32I instruction encoder: the inverse of the core's instruction decoder. Accepts decoded fields (opcode, registers, funct3/funct7, full 32-bit immediate) over a valid/ready handshake, packs them into a 32-bit instruction word by format, tags each word with a sequential instruction-memory address, and buffers results in a small FIFO. Used by the test harness and loader path to program instruction memory, and as a golden model for round-trip decoder checks.

## Interface
- `BASE_ADDR`, 32'h0000_0000: address assigned to the first legal instruction after reset or `addr_clr`.
- `FIFO_DEPTH`, 4: output FIFO entries; power of two, at least 2.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous reset, active-high.
- `in_valid` in 1: field bundle valid.
- `in_ready` out 1: encoder can accept a bundle.
- `op` in 7: opcode.
- `rd`, `rs1`, `rs2` in 5 each: register indices.
- `funct3` in 3, `funct7` in 7: function fields.
- `imm` in 32: sign-extended immediate value, in decoder `Iimm/Simm/Bimm/Uimm/Jimm` convention.
- `addr_clr` in 1: reloads address counter with `BASE_ADDR`.
- `out_valid` out 1: FIFO head valid.
- `out_ready` in 1: consumer takes head.
- `out_inst` out 32: encoded instruction at head; 0 when empty.
- `out_addr` out 32: address of head; 0 when empty.
- `err` out 1: sticky error flag, cleared only by `rst`.
- `err_count` out 8: rejected bundles, saturates at 255.

## Operation
- Format by opcode: R 0110011; I 0010011, 0000011, 1100111, 1110011; S 0100011; B 1100011; U 0110111, 0010111; J 1101111. Any other opcode is illegal.
- R: {funct7, rs2, rs1, funct3, rd, op}.
- I: {imm[11:0], rs1, funct3, rd, op}.
- S: {imm[11:5], rs2, rs1, funct3, imm[4:0], op}.
- B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op}.
- U: {imm[31:12], rd, op}.
- J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
- Fields unused by a format are ignored.
- A bundle is accepted when `in_valid && in_ready`.
- A legal bundle writes {inst, addr} into the FIFO, then the address counter increments by 4. The counter wraps modulo 2^32.
- An illegal bundle is accepted and dropped. It sets `err`, increments `err_count`, and leaves the address unchanged.
- `in_ready` = FIFO not full. It does not depend on `out_ready` in the same cycle, so a full FIFO never accepts, even while popping.
- Pop when `out_valid && out_ready`. A simultaneous push and pop on a non-full FIFO keeps the occupancy unchanged.
- `addr_clr` in the same cycle as an accept: the accepted word takes the old address, and the counter loads `BASE_ADDR`, not old address + 4.

## Timing
- Reset values: `out_valid`=0, `out_inst`=0, `out_addr`=0, `err`=0, `err_count`=0, counter=`BASE_ADDR`, FIFO empty, `in_ready`=1 from the first post-reset cycle.
- Latency: a bundle accepted at edge N into an empty FIFO appears with `out_valid`=1 after edge N.
- Throughput: one bundle per cycle sustained while `out_ready`=1.
- `out_valid`, `out_inst` and `out_addr` hold stable while `out_valid && !out_ready`.
- `rst` mid-stream discards FIFO contents and any in-flight bundle, with no output that cycle.

## Configuration
- `Z_CORE_ENC_IMM_CHECK_EN` defined: an immediate that does not fit its format is illegal. Fit rules:
  - I/S: `imm` must equal the sign-extension of imm[11:0].
  - B: sign-extension of imm[12:0], and imm[0]=0.
  - J: sign-extension of imm[20:0], and imm[0]=0.
  - U: imm[11:0]=0.
  - Illegal bundles are handled as for an illegal opcode.
- Not defined: immediate bits outside the format are silently truncated, and only illegal opcodes raise `err`.

## Test plan
- After reset, with `out_ready`=1, send addi op=0010011, rd=2, rs1=0, funct3=0, imm=3 -> `out_inst`=0x00300113, `out_addr`=0x0, `out_valid` high one cycle after accept.
- Send sw (op=0100011, rs1=1, rs2=2, funct3=0, imm=16), then add (op=0110011, rd=3, rs1=1, rs2=2, funct3=0, funct7=0) back-to-back -> 0x00208823 @0x0, then 0x002081B3 @0x4.
- Send jal (rd=1, imm=2048), then lui (rd=5, imm=0x12345000) -> 0x001000EF, then 0x123452B7.
- Send op=0x7F between two legal bundles -> `err`=1, `err_count`=1, and the legal words carry consecutive addresses 0x0 and 0x4.
- With `FIFO_DEPTH`=4 and `out_ready`=0, hold `in_valid`=1 -> exactly 4 accepts, then `in_ready`=0. Raise `out_ready` with no further input -> 4 words drain in order, unchanged.
- With the macro defined, send addi with imm=0x800 -> rejected, `err`=1. Without the macro -> encoded as 0x80000113.
